pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage pipeline; successor to the single-flag flush detector. It resolves load-use, branch-in-ID and multicycle-EX hazards with a counted stall state machine. It also produces distinct PC-hold, IF/ID-hold, ID/EX-bubble, IF/ID-flush and EX-freeze controls, and keeps saturating stall/flush performance counters. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline register enables.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_detect.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classifier: how many bubble cycles the instruction in ID needs.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_branch,
  input  logic [AW-1:0] ex_rd,
  input  logic [AW-1:0] mem_rd,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          mem_memread,
  output logic [1:0]    need
);

  logic w_ex_match;
  logic w_mem_match;

  // Register 0 is hardwired to zero, so a write to it can never feed a consumer.
  assign w_ex_match  = ((ex_rd == id_rs && id_use_rs) || (ex_rd == id_rt && id_use_rt)) &&
                       ((ZERO_REG == 0) || (ex_rd != '0));
  assign w_mem_match = ((mem_rd == id_rs && id_use_rs) || (mem_rd == id_rt && id_use_rt)) &&
                       ((ZERO_REG == 0) || (mem_rd != '0));

  always_comb begin
    need = NEED_NONE;
    if (id_branch && ex_memread && w_ex_match) begin
      need = NEED_TWO;
    end else if (id_branch && ex_regwrite && w_ex_match) begin
      need = NEED_ONE;
    end else if (id_branch && mem_memread && w_mem_match) begin
      need = NEED_ONE;
    end else if (!id_branch && ex_memread && w_ex_match) begin
      need = NEED_ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside ID: counted stall FSM, EX-busy freeze, branch flush and
// saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int PERF_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              br_taken,
  input  logic [AW-1:0]     ex_rd,
  input  logic [AW-1:0]     mem_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic              ex_busy,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              ex_freeze,
  output logic              if_id_flush,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  state_e            r_state;
  state_e            w_next_state;
  logic [1:0]        r_left;
  logic [1:0]        w_next_left;
  logic [1:0]        w_need;
  logic              w_stall;
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_flush_count;
  logic              w_unused;

  // MEM-stage results are always forwarded, so a plain MEM write never stalls.
  assign w_unused = mem_regwrite;

  hazard_detect #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_branch   (id_branch),
    .ex_rd       (ex_rd),
    .mem_rd      (mem_rd),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .mem_memread (mem_memread),
    .need        (w_need)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
      r_left  <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_left  <= w_next_left;
    end
  end

  // A busy EX unit freezes the whole controller, including the remaining stall count.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    w_next_state = r_state;
    w_next_left  = r_left;
    if (!ex_busy) begin
      if (r_state == RUN) begin
        if (w_need == NEED_TWO) begin
          w_next_state = STALL;
          w_next_left  = 2'd1;
        end
      end else begin
        w_next_left = r_left - 2'd1;
        if (r_left == 2'd1) begin
          w_next_state = RUN;
        end
      end
    end
  end

  assign w_stall = !ex_busy && ((r_state == STALL) || (w_need != NEED_NONE));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_freeze    = 1'b0;
    if_id_flush  = 1'b0;
    if (Rst_n) begin
      if (ex_busy) begin
        ex_freeze   = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (w_stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (id_branch && br_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (id_ex_bubble && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
      if (if_id_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + PERF_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl; three parameterizations share
// one stimulus stream and are each compared against a remaining-bubble reference model.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, id_branch, br_taken;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic       ex_busy, perf_clr;

  wire [2:0]  pcw, ifw, bub, frz, fl;
  wire [15:0] sc0, fc0, sc1, fc1;
  wire [1:0]  sc2, fc2;

  int m_rem [3];
  int m_sc  [3];
  int m_fc  [3];
  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.AW(5), .ZERO_REG(1), .PERF_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_branch(id_branch), .br_taken(br_taken), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .ex_busy(ex_busy),
    .perf_clr(perf_clr), .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_bubble(bub[0]),
    .ex_freeze(frz[0]), .if_id_flush(fl[0]), .stall_cycles(sc0), .flush_count(fc0));

  pipeline_hazard_ctrl #(.AW(5), .ZERO_REG(0), .PERF_W(16)) dut_z0 (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_branch(id_branch), .br_taken(br_taken), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .ex_busy(ex_busy),
    .perf_clr(perf_clr), .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_bubble(bub[1]),
    .ex_freeze(frz[1]), .if_id_flush(fl[1]), .stall_cycles(sc1), .flush_count(fc1));

  pipeline_hazard_ctrl #(.AW(5), .ZERO_REG(1), .PERF_W(2)) dut_p2 (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_branch(id_branch), .br_taken(br_taken), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .ex_busy(ex_busy),
    .perf_clr(perf_clr), .pc_write(pcw[2]), .if_id_write(ifw[2]), .id_ex_bubble(bub[2]),
    .ex_freeze(frz[2]), .if_id_flush(fl[2]), .stall_cycles(sc2), .flush_count(fc2));

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s [dut %0d]: observed %0h expected %0h", tag, idx, obs, exp);
  endtask

  function automatic logic [31:0] get_sc(input int i);
    case (i)
      0:       return {16'b0, sc0};
      1:       return {16'b0, sc1};
      default: return {30'b0, sc2};
    endcase
  endfunction

  function automatic logic [31:0] get_fc(input int i);
    case (i)
      0:       return {16'b0, fc0};
      1:       return {16'b0, fc1};
      default: return {30'b0, fc2};
    endcase
  endfunction

  function automatic bit hits(input logic [4:0] rd, input bit zr);
    if (zr && rd == 5'd0) return 1'b0;
    return (rd == id_rs && id_use_rs) || (rd == id_rt && id_use_rt);
  endfunction

  function automatic int sat_add(input int v, input int inc, input int w);
    int max_v;
    max_v = (1 << w) - 1;
    return (v + inc > max_v) ? max_v : v + inc;
  endfunction

  // Reference: an instruction owes some number of bubbles; owed bubbles are paid one per
  // non-busy cycle before anything new is examined.
  function automatic void model_eval(input int i, output bit stall, output bit flush,
                                     output bit freeze, output int nrem);
    bit zr;
    bit mex, mmem;
    int need;
    zr   = (i != 1);
    mex  = hits(ex_rd, zr);
    mmem = hits(mem_rd, zr);
    need = 0;
    if (id_branch) begin
      if (ex_memread && mex) need = 2;
      else if ((ex_regwrite && mex) || (mem_memread && mmem)) need = 1;
    end else if (ex_memread && mex) begin
      need = 1;
    end
    stall  = 1'b0;
    flush  = 1'b0;
    freeze = 1'b0;
    nrem   = m_rem[i];
    if (!Rst_n) begin
      nrem = 0;
    end else if (ex_busy) begin
      freeze = 1'b1;
    end else begin
      if (m_rem[i] > 0) begin
        stall = 1'b1;
        nrem  = m_rem[i] - 1;
      end else if (need > 0) begin
        stall = 1'b1;
        nrem  = need - 1;
      end
      flush = !stall && id_branch && br_taken;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rem[i] = 0;
      m_sc[i]  = 0;
      m_fc[i]  = 0;
    end
  endtask

  task automatic tick();
    bit st [3];
    bit fe [3];
    bit fz [3];
    int nr [3];
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      model_eval(i, st[i], fe[i], fz[i], nr[i]);
      check("pc_write", i, pcw[i], !(st[i] || fz[i]));
      check("if_id_write", i, ifw[i], !(st[i] || fz[i]));
      check("id_ex_bubble", i, bub[i], st[i]);
      check("ex_freeze", i, frz[i], fz[i]);
      check("if_id_flush", i, fl[i], fe[i]);
      check("stall_cycles", i, get_sc(i), m_sc[i]);
      check("flush_count", i, get_fc(i), m_fc[i]);
    end
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      if (!Rst_n) begin
        m_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        m_rem[i] = nr[i];
        if (perf_clr) begin
          m_sc[i] = 0; m_fc[i] = 0;
        end else begin
          m_sc[i] = sat_add(m_sc[i], int'(st[i]), (i == 2) ? 2 : 16);
          m_fc[i] = sat_add(m_fc[i], int'(fe[i]), (i == 2) ? 2 : 16);
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_use_rs = 0; id_use_rt = 0; id_branch = 0; br_taken = 0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memread = 0;
    ex_busy = 0; perf_clr = 0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = r; id_rs = r; id_use_rs = 1;
  endtask

  task automatic set_branch_after_load(input logic [4:0] r);
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = r;
    id_branch = 1; br_taken = 1; id_rt = r; id_use_rt = 1;
  endtask

  task automatic set_branch_load_in_mem(input logic [4:0] r);
    clear_inputs();
    mem_memread = 1; mem_regwrite = 1; mem_rd = r;
    id_branch = 1; br_taken = 1; id_rt = r; id_use_rt = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    model_reset();
    Rst_n = 1'b0;
    #2;
    check("reset_pc_write", 0, pcw, 3'b111);
    check("reset_bubble", 0, bub, 3'b000);
    check("reset_flush", 0, fl, 3'b000);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    tick();

    // Load-use: exactly one bubble.
    set_load_use(5'd8);
    #3;
    check("lu_pc_write", 0, pcw, 3'b000);
    check("lu_bubble", 0, bub, 3'b111);
    tick();
    clear_inputs();
    tick();
    check("lu_stall_cycles", 0, sc0, 32'd1);

    // Branch after load: two bubbles, then the taken branch flushes once.
    set_branch_after_load(5'd9);
    #3;
    check("bl_bubble1", 0, bub, 3'b111);
    check("bl_no_flush", 0, fl, 3'b000);
    tick();
    set_branch_load_in_mem(5'd9);
    #3;
    check("bl_bubble2", 0, bub, 3'b111);
    tick();
    clear_inputs();
    id_branch = 1; br_taken = 1; id_rt = 5'd9; id_use_rt = 1;
    #3;
    check("bl_flush", 0, fl, 3'b111);
    check("bl_flush_pc_write", 0, pcw, 3'b111);
    tick();
    check("bl_flush_count", 0, fc0, 32'd1);
    clear_inputs();
    tick();
    check("bl_stall_cycles", 0, sc0, 32'd3);

    // Register 0 is exempt only when ZERO_REG=1.
    set_load_use(5'd0);
    #3;
    check("zr_bubble", 0, bub, 3'b010);
    tick();
    clear_inputs();
    tick();

    // EX busy in the middle of a two-bubble stall.
    set_branch_after_load(5'd4);
    tick();
    set_branch_load_in_mem(5'd4);
    ex_busy = 1;
    repeat (3) begin
      #3;
      check("busy_freeze", 0, frz, 3'b111);
      check("busy_bubble", 0, bub, 3'b000);
      check("busy_pc_write", 0, pcw, 3'b000);
      tick();
    end
    ex_busy = 0;
    #3;
    check("busy_release_bubble", 0, bub, 3'b111);
    tick();
    clear_inputs();
    id_branch = 1; br_taken = 1;
    #3;
    check("busy_pending_flush", 0, fl, 3'b111);
    tick();
    clear_inputs();
    tick();

    // Reset asserted mid-stall.
    set_branch_after_load(5'd6);
    tick();
    set_branch_load_in_mem(5'd6);
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pc_write", 0, pcw, 3'b111);
    check("rst_if_id_write", 0, ifw, 3'b111);
    check("rst_bubble", 0, bub, 3'b000);
    check("rst_freeze", 0, frz, 3'b000);
    check("rst_flush", 0, fl, 3'b000);
    check("rst_stall_cycles", 0, sc0, 32'd0);
    check("rst_flush_count", 0, fc0, 32'd0);
    check("rst_stall_cycles", 2, {30'b0, sc2}, 32'd0);
    clear_inputs();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    id_branch = 1; br_taken = 1;
    #3;
    check("post_rst_run_bubble", 0, bub, 3'b000);
    check("post_rst_run_flush", 0, fl, 3'b111);
    tick();
    clear_inputs();
    tick();

    // Saturation at PERF_W=2, then clear racing a stall.
    repeat (5) begin
      set_load_use(5'd3);
      tick();
      clear_inputs();
      tick();
    end
    check("sat_p2_stall_cycles", 2, {30'b0, sc2}, 32'd3);
    check("sat_p16_stall_cycles", 0, sc0, 32'd5);
    set_load_use(5'd3);
    perf_clr = 1;
    tick();
    check("clr_p2_stall_cycles", 2, {30'b0, sc2}, 32'd0);
    check("clr_p16_stall_cycles", 0, sc0, 32'd0);
    check("clr_p16_flush_count", 0, fc0, 32'd0);
    clear_inputs();
    tick();

    // Randomized traffic over a small register space to provoke frequent hazards.
    for (int n = 0; n < 400; n++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom);
      id_use_rt    = 1'($urandom);
      id_branch    = ($urandom_range(0, 2) == 0);
      br_taken     = 1'($urandom);
      ex_regwrite  = 1'($urandom);
      ex_memread   = 1'($urandom);
      mem_regwrite = 1'($urandom);
      mem_memread  = 1'($urandom);
      ex_busy      = ($urandom_range(0, 5) == 0);
      perf_clr     = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
